// File: rtl/rutadatos_booth.sv
// rtl/rutadatos_booth.sv - Radix-2 Booth multiplier datapath: operand/accumulator registers,
// add/sub/shift execution and product capture on the rising edge of fin.
module rutadatos_booth #(
   parameter int N = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   multiplicando,
   input  logic [N-1:0]   multiplicador,
   input  logic           inic,
   input  logic           cargasuma,
   input  logic           resta,
   input  logic           desplaza,
   input  logic           fin,
   output logic           q0,
   output logic           qmenos1,
   output logic [2*N-1:0] producto,
   output logic           listo
);

   logic [N-1:0]   r_m;
   logic [N:0]     r_a;
   logic [N-1:0]   r_q;
   logic           r_q1;
   logic           r_fin_d;
   logic [2*N-1:0] r_producto;
   logic           r_listo;

   logic [N:0]     w_m_ext;
   logic [N:0]     w_sum;
   logic           w_fin_rise;

   // One extra accumulator bit keeps A - (-2^(N-1)) representable.
   assign w_m_ext    = {r_m[N-1], r_m};
   assign w_sum      = resta ? (r_a - w_m_ext) : (r_a + w_m_ext);
   assign w_fin_rise = fin & ~r_fin_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m  <= '0;
         r_a  <= '0;
         r_q  <= '0;
         r_q1 <= 1'b0;
      end else if (inic) begin
         r_m  <= multiplicando;
         r_q  <= multiplicador;
         r_a  <= '0;
         r_q1 <= 1'b0;
      end else if (cargasuma) begin
         r_a  <= w_sum;
      end else if (desplaza) begin
         r_a  <= {r_a[N], r_a[N:1]};
         r_q  <= {r_a[0], r_q[N-1:1]};
         r_q1 <= r_q[0];
      end
   end

   // Capture samples A/Q as they stood before this edge's datapath action.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fin_d    <= 1'b0;
         r_producto <= '0;
         r_listo    <= 1'b0;
      end else begin
         r_fin_d <= fin;
         r_listo <= w_fin_rise;
         if (w_fin_rise) begin
            r_producto <= {r_a[N-1:0], r_q};
         end
      end
   end

   assign q0       = r_q[0];
   assign qmenos1  = r_q1;
   assign producto = r_producto;
   assign listo    = r_listo;

endmodule

// File: tb/tb_rutadatos_booth.sv
// tb/tb_rutadatos_booth.sv - Randomized scoreboard bench for rutadatos_booth
// against a plain signed-multiplication reference.
module tb_rutadatos_booth;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   multiplicando = '0;
   logic [N-1:0]   multiplicador = '0;
   logic           inic = 1'b0;
   logic           cargasuma = 1'b0;
   logic           resta = 1'b0;
   logic           desplaza = 1'b0;
   logic           fin = 1'b0;
   logic           q0;
   logic           qmenos1;
   logic [2*N-1:0] producto;
   logic           listo;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2*N-1:0] exp_q[$];

   rutadatos_booth #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .multiplicando(multiplicando), .multiplicador(multiplicador),
      .inic(inic), .cargasuma(cargasuma), .resta(resta), .desplaza(desplaza),
      .fin(fin), .q0(q0), .qmenos1(qmenos1), .producto(producto), .listo(listo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
      int p;
      p = int'($signed(m)) * int'($signed(q));
      return p[2*N-1:0];
   endfunction

   // Scoreboard monitor: every listo pulse must match the oldest expected product.
   always @(negedge clk) begin
      if (listo) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_listo", 32'(producto), 32'hFFFF_FFFF);
         end else begin
            logic [2*N-1:0] e;
            e = exp_q.pop_front();
            chk("producto", 32'(producto), 32'(e));
         end
      end
   end

   // Drives the nominal controller sequence; Booth table: step i examines Q[i], Q[i-1].
   task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                         input int hold, input bit abort);
      logic b0, b1;
      @(negedge clk);
      inic = 1'b1; multiplicando = m; multiplicador = q;
      cargasuma = 1'b0; desplaza = 1'b0; resta = 1'b0;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         inic = 1'b0; fin = 1'b0; desplaza = 1'b0;
         b0 = q[i];
         b1 = (i == 0) ? 1'b0 : q[i-1];
         chk("q0_step", 32'(q0), 32'(b0));
         chk("qmenos1_step", 32'(qmenos1), 32'(b1));
         if (abort && i == 1) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_q0", 32'(q0), 0);
            chk("rst_qmenos1", 32'(qmenos1), 0);
            chk("rst_producto", 32'(producto), 0);
            chk("rst_listo", 32'(listo), 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         cargasuma = (b0 != b1);
         resta = b0 & ~b1;
         @(negedge clk);
         cargasuma = 1'b0; resta = 1'b0; desplaza = 1'b1;
      end
      @(negedge clk);
      desplaza = 1'b0; fin = 1'b1;
      exp_q.push_back(ref_mul(m, q));
      if (hold == 0) begin
         @(negedge clk);
         fin = 1'b0;
      end else begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("producto_hold", 32'(producto), 32'(ref_mul(m, q)));
         end
      end
   endtask

   initial begin
      logic [N-1:0] rm, rq;
      #12;
      chk("reset_q0", 32'(q0), 0);
      chk("reset_qmenos1", 32'(qmenos1), 0);
      chk("reset_producto", 32'(producto), 0);
      chk("reset_listo", 32'(listo), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'd3, 3'd2, 0, 0);
      run_op(3'b100, 3'b100, 0, 0);
      run_op(3'd3, 3'b111, 0, 0);
      run_op(3'b101, 3'd3, 0, 0);
      run_op(3'd3, 3'd2, 10, 0);
      run_op(3'd2, 3'd3, 0, 0);
      run_op(3'd1, 3'd2, 0, 1);
      run_op(3'b110, 3'b011, 0, 0);

      // Combined command cycle: cargasuma wins, shift suppressed; then inic wins over cargasuma.
      @(negedge clk);
      inic = 1'b1; multiplicando = 3'd1; multiplicador = 3'd3;
      @(negedge clk);
      inic = 1'b0; cargasuma = 1'b1; desplaza = 1'b1; resta = 1'b1;
      @(negedge clk);
      cargasuma = 1'b0; desplaza = 1'b0; resta = 1'b0; fin = 1'b1;
      exp_q.push_back({3'b111, 3'd3});
      @(negedge clk);
      fin = 1'b0; inic = 1'b1; cargasuma = 1'b1; multiplicando = 3'd2; multiplicador = 3'd5;
      @(negedge clk);
      inic = 1'b0; cargasuma = 1'b0; fin = 1'b1;
      exp_q.push_back({3'b000, 3'd5});
      @(negedge clk);
      fin = 1'b0;

      for (int k = 0; k < 24; k++) begin
         rm = N'($urandom_range(0, (1 << N) - 1));
         rq = N'($urandom_range(0, (1 << N) - 1));
         run_op(rm, rq, (k % 6 == 5) ? 3 : 0, 0);
      end

      @(negedge clk);
      fin = 1'b0;
      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rutadatos_booth.md
Name: rutadatos_booth

Overview:
Datapath for the radix-2 Booth sequential multiplier. It holds the multiplicand, the accumulator, the multiplier/shift register and the Q-1 bit. It executes the inic, cargasuma/resta and desplaza commands issued cycle by cycle by the Booth control unit, and returns q0/qmenos1 so the controller can decide each step. When the controller raises fin, the block latches the signed 2N-bit product and pulses listo to the consumer.

Parameters:
N, 3, operand width in bits (two's complement). Equals the controller's add/shift iteration count.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
multiplicando  input  N  signed M, sampled on inic
multiplicador  input  N  signed Q, sampled on inic
inic  input  1  load operands, clear accumulator
cargasuma  input  1  write accumulator with add/sub result
resta  input  1  selects subtract when cargasuma=1
desplaza  input  1  arithmetic right shift of {A,Q,Q-1}
fin  input  1  controller finished, level
q0  output  1  Q[0], to controller
qmenos1  output  1  Q-1 bit, to controller
producto  output  2N  registered signed product
listo  output  1  one-cycle pulse: producto updated

Behaviour:
- Internal registers:
  - M: N bits.
  - A: N+1 bits. The extra sign bit prevents overflow when M = -2^(N-1).
  - Q: N bits.
  - q_1: 1 bit.
  - fin_d: 1 bit.
- Reset (rst_n=0, async): A, Q, M, q_1, fin_d, producto and listo all go to 0, so q0=0 and qmenos1=0. All registers hold reset while rst_n=0. Reset mid-operation discards all state, with no partial product or listo afterwards.
- At each posedge clk, in priority order (exactly one action):
  1. inic=1: M<=multiplicando, Q<=multiplicador, A<=0, q_1<=0. cargasuma, desplaza and resta are ignored.
  2. cargasuma=1: A <= resta ? A - sext(M) : A + sext(M), both (N+1)-bit, modulo 2^(N+1). Q and q_1 hold. desplaza is ignored if also high.
  3. desplaza=1: {A,Q,q_1} <= {A[N],A,Q}, i.e. arithmetic shift right by 1 of the 2N+2-bit concatenation.
  4. Otherwise: A, Q, M, q_1 hold.
- resta has effect only together with cargasuma (the controller drives it ungated).
- q0 = Q[0]; qmenos1 = q_1. Both are combinational from registers, with zero latency to the controller.
- Completion:
  - fin_d <= fin every cycle.
  - On a posedge with fin=1 and fin_d=0: producto <= {A[N-1:0],Q} and listo <= 1.
  - On every other posedge: listo <= 0, and producto holds.
  - listo is high exactly one cycle per rising fin, even if fin stays high indefinitely.
  - The capture uses the register values before that edge's action.
- inic while fin=1 is legal and reloads the operands. fin then falls with the controller's restart, and the next rising fin produces a new pulse.
- Nominal control sequence for N=3:
  - s0: inic.
  - s1, s3, s5: cargasuma if q0≠qmenos1, with resta = q0 & ~qmenos1.
  - s2, s4, s6: desplaza.
  - s7: fin.
- Product is valid for all signed operand pairs, including (-2^(N-1))·(-2^(N-1)).
- Final capture fires at the first edge with fin=1, which falls in s7.

Test Plan:
1. N=3, M=3 (011), Q=2 (010), nominal controller sequence -> q0/qmenos1 steps match Booth table; producto=000110 (6); listo high for exactly one cycle, the cycle after the first edge with fin=1.
2. M=-4 (100), Q=-4 (100) -> producto=010000 (16); accumulator MSB never corrupts (overflow corner).
3. M=3, Q=-1 (111) -> producto=111101 (-3); M=-3, Q=3 -> producto=110111 (-9).
4. fin held high for 10 cycles after completion -> listo pulses once, producto stable; fin low then high again after a new inic (M=2, Q=3) -> second pulse, producto=000110.
5. rst_n pulled low asynchronously mid-clock during s3 -> A, Q, producto, listo, q0, qmenos1 go to 0 immediately; no listo until a full new inic..fin run.
6. Forced cargasuma=1, desplaza=1, resta=1 in the same cycle with A=0, M=1 -> A=-1 (1111), no shift applied; then inic=1 with cargasuma=1 -> A=0, operands reloaded.
